// File: rtl/ram16k_ctrl.sv
// Valid/ready request front-end for the 16K x 16 gate-level RAM.
// Define RAM16K_CTRL_BURST_EN to honour req_len (bursts and fills).
module ram16k_ctrl #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              mem_en,
    output logic              mem_w,
    output logic              mem_r,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_d_in,
    input  logic [DATA_W-1:0] mem_d_out
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic [LEN_W-1:0]    w_len;
    logic                w_cnt_zero;

`ifdef RAM16K_CTRL_BURST_EN
    assign w_len = req_len;
`else
    logic w_unused_len;
    assign w_len        = '0;
    assign w_unused_len = ^req_len;
`endif

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_rdata <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rsp_rdata;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_cnt_nxt   = w_len;
                    w_state_nxt = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt - LEN_W'(1);
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            READ: begin
                w_rdata_nxt = mem_d_out;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (w_cnt_zero) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt - LEN_W'(1);
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = READ;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Every output is a decode of registered state only.
    assign req_ready = (r_state == IDLE);
    assign mem_w     = (r_state == WRITE);
    assign mem_r     = (r_state == READ);
    assign mem_en    = mem_w | mem_r;
    assign mem_add   = r_addr;
    assign mem_d_in  = r_wdata;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;

`ifdef RAM16K_CTRL_BURST_EN
    assign rsp_last = rsp_valid & w_cnt_zero;
`else
    assign rsp_last = rsp_valid;
`endif

endmodule

// File: tb/tb_ram16k_ctrl.sv
// Scoreboard bench for ram16k_ctrl with a behavioural RAM model.
// Burst scenarios run only when RAM16K_CTRL_BURST_EN is defined.
module tb_ram16k_ctrl;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int LW = 8;
`ifdef RAM16K_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [LW-1:0] req_len = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          mem_en;
    logic          mem_w;
    logic          mem_r;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_d_in;
    logic [DW-1:0] mem_d_out;

    ram16k_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .mem_en    (mem_en),
        .mem_w     (mem_w),
        .mem_r     (mem_r),
        .mem_add   (mem_add),
        .mem_d_in  (mem_d_in),
        .mem_d_out (mem_d_out)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en && mem_w) ram[mem_add] <= mem_d_in;
    end
    assign mem_d_out = ram[mem_add];

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_rd  = 0;
    int n_rsp = 0;
    logic [DW:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en && mem_w) n_wr++;
            if (mem_en && mem_r) n_rd++;
            if (rsp_valid && rsp_ready) begin
                logic [DW:0] e;
                n_rsp++;
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_rdata), 32'hDEAD_0000);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e[DW-1:0]));
                    check("rsp_last", 32'(rsp_last), 32'(e[DW]));
                end
            end
        end
    end

    task automatic wait_ready();
        int i = 0;
        while (!req_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send_req(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [LW-1:0] l);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_len   = l;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int i = 0;
        while (sb_q.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (sb_q.size() != 0) check("rsp_timeout", 32'(sb_q.size()), 0);
        wait_ready();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_req(1'b1, a, d, '0);
        wait_ready();
    endtask

    task automatic read1(input logic [AW-1:0] a, input logic [DW-1:0] e);
        sb_q.push_back({1'b1, e});
        send_req(1'b0, a, '0, '0);
        wait_empty();
    endtask

    int base;
    int nb;
    logic [AW-1:0] wrap_a [4];

    initial begin
        wrap_a[0] = 14'h3FFE;
        wrap_a[1] = 14'h3FFF;
        wrap_a[2] = 14'h0000;
        wrap_a[3] = 14'h0001;

        #3;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_last", 32'(rsp_last), 0);
        check("rst_mem_strobes", 32'({mem_en, mem_w, mem_r}), 0);
        check("rst_mem_add", 32'(mem_add), 0);
        check("rst_mem_d_in", 32'(mem_d_in), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single write, then single read
        base = n_wr;
        send_req(1'b1, 14'h0005, 16'hBEEF, 8'h00);
        @(negedge clk);
        check("wr_mem_w", 32'({mem_en, mem_w, mem_r}), 32'b110);
        check("wr_mem_add", 32'(mem_add), 32'h5);
        check("wr_mem_d_in", 32'(mem_d_in), 32'hBEEF);
        wait_ready();
        @(negedge clk);
        check("wr_pulse_count", 32'(n_wr - base), 1);

        sb_q.push_back({1'b1, 16'hBEEF});
        send_req(1'b0, 14'h0005, '0, 8'h00);
        @(negedge clk);
        check("rd_mem_r", 32'({mem_en, mem_w, mem_r}), 32'b101);
        check("rd_not_yet_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        check("rd_valid_next", 32'(rsp_valid), 1);
        wait_empty();

        // busy rejection during a fill (4 beats when bursts are enabled)
        nb = BURST ? 4 : 1;
        base = n_wr;
        send_req(1'b1, 14'h0100, 16'h1234, 8'd3);
        req_we    = 1'b0;
        req_addr  = 14'h0005;
        req_len   = 8'd0;
        req_valid = 1'b1;
        sb_q.push_back({1'b1, 16'hBEEF});
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            check("busy_ready_low", 32'(req_ready), 0);
            check("busy_mem_add", 32'(mem_add), 32'h100 + i);
        end
        @(negedge clk);
        check("busy_first_idle", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_empty();
        check("busy_wr_count", 32'(n_wr - base), 32'(nb));
        read1(14'h0100, 16'h1234);

        do_write(14'h0010, 16'd1);
        do_write(14'h0011, 16'd2);
        do_write(14'h0012, 16'd3);

`ifdef RAM16K_CTRL_BURST_EN
        // wrapping fill
        send_req(1'b1, 14'h3FFE, 16'hA5A5, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_mem_w", 32'(mem_w), 1);
            check("wrap_mem_add", 32'(mem_add), 32'(wrap_a[i]));
        end
        @(negedge clk);
        check("wrap_done_ready", 32'(req_ready), 1);
        for (int i = 0; i < 4; i++) read1(wrap_a[i], 16'hA5A5);

        // burst read with a 3-cycle stall on the first beat
        rsp_ready = 1'b0;
        sb_q.push_back({1'b0, 16'd1});
        sb_q.push_back({1'b0, 16'd2});
        sb_q.push_back({1'b1, 16'd3});
        base = n_rd;
        send_req(1'b0, 14'h0010, '0, 8'd2);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_rdata", 32'(rsp_rdata), 1);
            check("stall_mem_r", 32'(mem_r), 0);
            @(negedge clk);
        end
        #1 rsp_ready = 1'b1;
        wait_empty();
        check("burst_rd_count", 32'(n_rd - base), 3);
`else
        // req_len is ignored: one beat only
        base = n_rd;
        nb = n_rsp;
        sb_q.push_back({1'b1, 16'd1});
        send_req(1'b0, 14'h0010, '0, 8'd5);
        wait_empty();
        repeat (6) @(negedge clk);
        check("nob_rd_count", 32'(n_rd - base), 1);
        check("nob_rsp_count", 32'(n_rsp - nb), 1);
        check("nob_idle", 32'(req_ready), 1);
`endif

        // reset while holding the first response of a 3-beat read
        rsp_ready = 1'b0;
        send_req(1'b0, 14'h0010, '0, 8'd2);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 0);
        check("rst_mid_strobes", 32'({mem_en, mem_r}), 0);
        check("rst_mid_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        read1(14'h0005, 16'hBEEF);
        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
